seq_divider: RTL and testbench

Parametrised signed sequential divider: a fixed-latency, radix-2 shift-subtract successor to the team's repeated-subtraction divider. It returns a saturated narrow quotient plus a full-width remainder, and flags divide-by-zero and overflow. It sits in the physics/rendering datapath wherever a ratio of two signed fixed-width quantities is needed. Latency does not depend on operand values, so upstream schedulers can pipeline around it.

---
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: signed radix-2 restoring divider with fixed WIDTH+2 cycle latency.
// Optional quotient saturation via SEQ_DIVIDER_SATURATE_EN.
module seq_divider #(
    parameter int WIDTH    = 32,
    parameter int OUT_SIZE = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [WIDTH-1:0]    dividend_in,
    input  logic [WIDTH-1:0]    divisor_in,
    input  logic                data_valid_in,
    output logic [OUT_SIZE-1:0] quotient_out,
    output logic [WIDTH-1:0]    remainder_out,
    output logic                data_valid_out,
    output logic                error_out,
    output logic                overflow_out,
    output logic                busy_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [OUT_SIZE-1:0] QMIN = OUT_SIZE'(1) << (OUT_SIZE - 1);
    localparam logic [OUT_SIZE-1:0] QMAX = ~QMIN;

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;
    state_t state, state_nx;

    logic [WIDTH:0]    rem, quo, dvs, shl, qs, rs, ext_n, ext_d, mag_n, mag_d;
    logic [WIDTH-1:0]  num;
    logic [CW-1:0]     cnt;
    logic              sn, sd, zero, start, take, ovf;
    logic [OUT_SIZE-1:0] qo;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;

    always_comb begin
        start    = state == IDLE && data_valid_in;
        state_nx = start ? DIVIDE :
                   (state == DIVIDE && cnt == '0) ? FINISH :
                   state == FINISH ? IDLE : state;
        ext_n    = {dividend_in[WIDTH-1], dividend_in};
        ext_d    = {divisor_in[WIDTH-1], divisor_in};
        mag_n    = ext_n[WIDTH] ? -ext_n : ext_n;
        mag_d    = ext_d[WIDTH] ? -ext_d : ext_d;
        shl      = {rem[WIDTH-1:0], quo[WIDTH-1]};
        take     = shl >= dvs;
        qs       = (sn ^ sd) ? -{1'b0, quo[WIDTH-1:0]} : {1'b0, quo[WIDTH-1:0]};
        rs       = sn ? -rem : rem;
`ifdef SEQ_DIVIDER_SATURATE_EN
        // fits iff every bit from the OUT_SIZE sign position up is a sign copy
        ovf      = !(&qs[WIDTH:OUT_SIZE-1] || !(|qs[WIDTH:OUT_SIZE-1]));
        qo       = ovf ? (qs[WIDTH] ? QMIN : QMAX) : qs[OUT_SIZE-1:0];
`else
        ovf      = 1'b0;
        qo       = qs[OUT_SIZE-1:0];
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            num            <= '0;
            cnt            <= '0;
            sn             <= 1'b0;
            sd             <= 1'b0;
            zero           <= 1'b0;
            quotient_out   <= '0;
            remainder_out  <= '0;
            data_valid_out <= 1'b0;
            error_out      <= 1'b0;
            overflow_out   <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (start) begin
                sn       <= dividend_in[WIDTH-1];
                sd       <= divisor_in[WIDTH-1];
                zero     <= divisor_in == '0;
                num      <= dividend_in;
                quo      <= mag_n;
                dvs      <= mag_d;
                rem      <= '0;
                cnt      <= CW'(WIDTH - 1);
                busy_out <= 1'b1;
            end else if (state == DIVIDE) begin
                rem <= take ? shl - dvs : shl;
                quo <= {quo[WIDTH-1:0], take};
                cnt <= cnt - 1'b1;
            end else if (state == FINISH) begin
                quotient_out   <= zero ? '0 : qo;
                remainder_out  <= zero ? num : rs[WIDTH-1:0];
                error_out      <= zero;
                overflow_out   <= !zero && ovf;
                data_valid_out <= 1'b1;
                busy_out       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=32, OUT_SIZE=8).
module tb_seq_divider;
    logic        clk = 1'b0, rst = 1'b0, vin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  q;
    logic [31:0] r;
    logic        dv, err, ovf, busy;
    int          vectors = 0, miscompares = 0, lat, seen;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32), .OUT_SIZE(8)) dut (
        .clk_in(clk), .rst_in(rst), .dividend_in(a), .divisor_in(b),
        .data_valid_in(vin), .quotient_out(q), .remainder_out(r),
        .data_valid_out(dv), .error_out(err), .overflow_out(ovf), .busy_out(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x; b = y; vin = 1'b1;
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    // counts cycles after the acceptance edge until data_valid_out is seen
    task automatic wait_done(input int from, output int n);
        n = from;
        do begin
            @(negedge clk);
            n++;
        end while (!dv && n < 100);
        if (!dv) n = -1;
    endtask

    task automatic result(input string tag, input logic [7:0] eq, input logic [31:0] er,
                          input logic ee, input logic eo);
        check({tag, ".lat"}, lat, 34);
        check({tag, ".q"}, {24'b0, q}, {24'b0, eq});
        check({tag, ".r"}, r, er);
        check({tag, ".err"}, {31'b0, err}, {31'b0, ee});
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
    endtask

    initial begin
        @(negedge clk);
        check("rst.q", {24'b0, q}, 0);
        check("rst.r", r, 0);
        check("rst.flags", {26'b0, dv, err, ovf, busy}, 0);
        rst = 1'b1;

        issue(100, 7);
        check("busy_rise", {31'b0, busy}, 1);
        wait_done(0, lat);
        result("100/7", 8'd14, 32'd2, 1'b0, 1'b0);
        check("busy_fall", {31'b0, busy}, 0);
        @(negedge clk);
        check("pulse_len", {31'b0, dv}, 0);

        issue(-100, 7);
        wait_done(0, lat);
        result("-100/7", 8'hF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(100, -7);
        wait_done(0, lat);
        result("100/-7", 8'hF2, 32'd2, 1'b0, 1'b0);
        issue(-100, -7);
        wait_done(0, lat);
        result("-100/-7", 8'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);

        issue(1000, 3);
        wait_done(0, lat);
`ifdef SEQ_DIVIDER_SATURATE_EN
        result("1000/3", 8'd127, 32'd1, 1'b0, 1'b1);
`else
        result("1000/3", 8'd77, 32'd1, 1'b0, 1'b0);
`endif
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat);
`ifdef SEQ_DIVIDER_SATURATE_EN
        result("min/-1", 8'd127, 32'd0, 1'b0, 1'b1);
`else
        result("min/-1", 8'd0, 32'd0, 1'b0, 1'b0);
`endif

        issue(5, 0);
        wait_done(0, lat);
        result("5/0", 8'd0, 32'd5, 1'b1, 1'b0);

        issue(20, 3);
        repeat (9) @(negedge clk);
        a = 50; b = 2; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        wait_done(10, lat);
        result("20/3", 8'd6, 32'd2, 1'b0, 1'b0);
        a = -50; b = 3; vin = 1'b1;
        @(posedge clk);
        #1 vin = 1'b0;
        check("b2b_busy", {31'b0, busy}, 1);
        wait_done(0, lat);
        result("-50/3", 8'hF0, 32'hFFFF_FFFE, 1'b0, 1'b0);

        issue(100, 7);
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst.q", {24'b0, q}, 0);
        check("arst.r", r, 0);
        check("arst.flags", {26'b0, dv, err, ovf, busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dv) seen++;
        end
        check("no_spurious", seen, 0);
        check("idle_busy", {31'b0, busy}, 0);

        issue(7, 7);
        wait_done(0, lat);
        result("7/7", 8'd1, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
